ps2_scancode_rx: RTL and testbench

//  Receives PS/2 keyboard frames on ps2c/ps2d and checks start, odd parity and stop bits.

---
 rtl/ps2_scancode_rx.sv | 262 ++++++++++++++++++++++++++
 tb/tb_ps2_scancode_rx.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_rx.sv
// ---------------------------------------------------------------------------
// ps2_scancode_rx
//
// Receives PS/2 keyboard frames (start, 8 data bits LSB first, odd parity,
// stop) and turns them into one scan code per key press.  The E0 (extended)
// and F0 (break) prefix bytes are absorbed into flags and never appear on
// dato_tec.  tick feeds interrupt_teclado, and the PicoBlaze reads dato_tec
// through in_port.
//
// Ports
//   reloj      in   1  system clock (100 MHz)
//   reset      in   1  synchronous, active-high
//   ps2c       in   1  PS/2 clock, asynchronous
//   ps2d       in   1  PS/2 data, asynchronous
//   dato_tec   out  8  last accepted scan code, held until the next one
//   tick       out  1  one-cycle pulse, dato_tec/is_ext/is_break valid
//   is_ext     out  1  accepted code was preceded by E0
//   is_break   out  1  accepted code was preceded by F0 (REPORT_BREAK=1 only)
//   frame_err  out  1  one-cycle pulse on bad start/parity/stop or timeout
//   state_dbg  out  2  current frame FSM state (IDLE=0, DATA=1, PARITY=2,
//                      STOP=3), for observation only
//
// Handshake: tick is a strobe with no back-pressure.  dato_tec, is_ext and
// is_break are valid while tick is high and keep their values until the next
// tick; a consumer that misses the strobe can still read the held value.
// ---------------------------------------------------------------------------
module ps2_scancode_rx #(
    parameter int FILTER_LEN   = 8,
    parameter int TIMEOUT_CYC  = 100000,
    parameter int REPORT_BREAK = 0
) (
    input  logic       reloj,
    input  logic       reset,
    input  logic       ps2c,
    input  logic       ps2d,
    output logic [7:0] dato_tec,
    output logic       tick,
    output logic       is_ext,
    output logic       is_break,
    output logic       frame_err,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    localparam int             TW      = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [7:0]     CODE_EXT = 8'hE0;
    localparam logic [7:0]     CODE_BRK = 8'hF0;

    // -----------------------------------------------------------------------
    // Two-flop synchronisers.  Both lines idle high, so they reset to 1 to
    // avoid a spurious falling edge right after reset.
    // -----------------------------------------------------------------------
    logic c_s1, c_s2;
    logic d_s1, d_s2;

    always_ff @(posedge reloj) begin
        if (reset) begin
            c_s1 <= 1'b1;
            c_s2 <= 1'b1;
            d_s1 <= 1'b1;
            d_s2 <= 1'b1;
        end else begin
            c_s1 <= ps2c;
            c_s2 <= c_s1;
            d_s1 <= ps2d;
            d_s2 <= d_s1;
        end
    end

    // -----------------------------------------------------------------------
    // Glitch filter on the PS/2 clock.  The filtered clock only changes once
    // FILTER_LEN consecutive samples agree; anything shorter is ignored.
    // -----------------------------------------------------------------------
    logic [FILTER_LEN-1:0] filt_sr;
    logic                  filt_clk;
    logic                  fall;

    always_ff @(posedge reloj) begin
        if (reset) begin
            filt_sr  <= '1;
            filt_clk <= 1'b1;
        end else begin
            filt_sr <= {filt_sr[FILTER_LEN-2:0], c_s2};
            if (&filt_sr) begin
                filt_clk <= 1'b1;
            end else if (~|filt_sr) begin
                filt_clk <= 1'b0;
            end
        end
    end

    // The cycle in which the filtered clock is about to drop is the falling
    // edge; ps2d (synchronised) is sampled in this same cycle.
    assign fall = filt_clk & ~|filt_sr;

    // -----------------------------------------------------------------------
    // Frame FSM: state register
    // -----------------------------------------------------------------------
    state_t state_q, state_d;

    always_ff @(posedge reloj) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Frame datapath: bit counter, shift register, parity bit, timeout
    // -----------------------------------------------------------------------
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_q;
    logic          par_q;
    logic [TW-1:0] to_cnt;
    logic          timeout_c;
    logic          parity_ok;

    // Odd parity: data bits plus parity bit must contain an odd count of 1s.
    assign parity_ok = ^{shift_q, par_q};

    // The timeout only runs while a frame is in progress; every falling edge
    // restarts it.
    assign timeout_c = (state_q != ST_IDLE) && !fall && (to_cnt == TO_LAST);

    always_ff @(posedge reloj) begin
        if (reset || (state_q == ST_IDLE) || fall) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    always_ff @(posedge reloj) begin
        if (reset) begin
            bit_cnt <= 3'd0;
            shift_q <= 8'h00;
            par_q   <= 1'b0;
        end else if (fall) begin
            case (state_q)
                ST_IDLE: begin
                    bit_cnt <= 3'd0;
                end
                ST_DATA: begin
                    // LSB arrives first, so shift in from the top.
                    shift_q <= {d_s2, shift_q[7:1]};
                    bit_cnt <= bit_cnt + 3'd1;
                end
                ST_PARITY: begin
                    par_q <= d_s2;
                end
                default: begin
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Frame FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (timeout_c) begin
            state_d = ST_IDLE;
        end else if (fall) begin
            case (state_q)
                ST_IDLE:   state_d = d_s2 ? ST_IDLE : ST_DATA;
                ST_DATA:   state_d = (bit_cnt == 3'd7) ? ST_PARITY : ST_DATA;
                ST_PARITY: state_d = ST_STOP;
                ST_STOP:   state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Frame FSM: output logic
    //   accept_c : a complete, well-formed byte sits in shift_q this cycle
    //   err_c    : bad start/parity/stop bit, or a frame timeout
    // -----------------------------------------------------------------------
    logic accept_c;
    logic err_c;

    always_comb begin
        accept_c = 1'b0;
        err_c    = 1'b0;
        if (timeout_c) begin
            err_c = 1'b1;
        end else if (fall) begin
            case (state_q)
                ST_IDLE: begin
                    err_c = d_s2;
                end
                ST_STOP: begin
                    if (d_s2 && parity_ok) begin
                        accept_c = 1'b1;
                    end else begin
                        err_c = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign state_dbg = state_q;

    // -----------------------------------------------------------------------
    // Byte decode and output registers.  Everything is registered from the
    // stop-bit cycle, so tick lands exactly one cycle after it.  accept_c and
    // err_c are mutually exclusive, so tick and frame_err never coincide.
    // -----------------------------------------------------------------------
    logic ext_flag;
    logic brk_flag;

    always_ff @(posedge reloj) begin
        if (reset) begin
            dato_tec  <= 8'h00;
            tick      <= 1'b0;
            is_ext    <= 1'b0;
            is_break  <= 1'b0;
            frame_err <= 1'b0;
            ext_flag  <= 1'b0;
            brk_flag  <= 1'b0;
        end else begin
            tick      <= 1'b0;
            frame_err <= err_c;

            if (timeout_c) begin
                // An abandoned frame may have been the code the prefixes
                // belonged to, so they are not carried over.
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
            end else if (accept_c) begin
                if (shift_q == CODE_EXT) begin
                    ext_flag <= 1'b1;
                end else if (shift_q == CODE_BRK) begin
                    brk_flag <= 1'b1;
                end else begin
                    ext_flag <= 1'b0;
                    brk_flag <= 1'b0;
                    // Release codes are dropped unless explicitly requested.
                    if (!brk_flag || (REPORT_BREAK != 0)) begin
                        dato_tec <= shift_q;
                        is_ext   <= ext_flag;
                        is_break <= brk_flag;
                        tick     <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// ---------------------------------------------------------------------------
// tb_ps2_scancode_rx
//
// Drives one PS/2 line into two receivers (REPORT_BREAK=0 and =1).  A
// reference model predicts, per receiver, the sequence of output events
// (tick with code/flags, or frame_err with held outputs) and queues them.
// A monitor pops and compares whenever a receiver pulses tick or frame_err,
// and checks that the held outputs never change without a tick.
// ---------------------------------------------------------------------------
module tb_ps2_scancode_rx;

    localparam int FL   = 8;
    localparam int TO   = 2000;
    localparam int HALF = 30;
    localparam int W    = 12;   // {err, tick, is_break, is_ext, dato[7:0]}

    // ------------------------------------------------------------ clock/reset
    logic reloj = 1'b0;
    logic reset = 1'b1;
    logic ps2c  = 1'b1;
    logic ps2d  = 1'b1;

    always #5 reloj = ~reloj;

    logic [7:0] dato      [2];
    logic       tick      [2];
    logic       is_ext    [2];
    logic       is_break  [2];
    logic       frame_err [2];
    logic [1:0] state_dbg [2];

    ps2_scancode_rx #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO), .REPORT_BREAK(0)) dut_mk (
        .reloj(reloj), .reset(reset), .ps2c(ps2c), .ps2d(ps2d),
        .dato_tec(dato[0]), .tick(tick[0]), .is_ext(is_ext[0]),
        .is_break(is_break[0]), .frame_err(frame_err[0]), .state_dbg(state_dbg[0])
    );

    ps2_scancode_rx #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO), .REPORT_BREAK(1)) dut_br (
        .reloj(reloj), .reset(reset), .ps2c(ps2c), .ps2d(ps2d),
        .dato_tec(dato[1]), .tick(tick[1]), .is_ext(is_ext[1]),
        .is_break(is_break[1]), .frame_err(frame_err[1]), .state_dbg(state_dbg[1])
    );

    // ------------------------------------------------------------ scoreboard
    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];
    int compared = 0;
    int failed   = 0;

    // Reference model: prefix flags and the outputs each receiver should hold.
    bit       m_ext = 1'b0;
    bit       m_brk = 1'b0;
    logic [9:0] last0 = 10'd0;   // {is_break, is_ext, dato}
    logic [9:0] last1 = 10'd0;

    task automatic model_good(input logic [7:0] b);
        if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            if (!m_brk) begin
                last0 = {1'b0, m_ext, b};
                exp_q0.push_back({2'b01, last0});
            end
            last1 = {m_brk, m_ext, b};
            exp_q1.push_back({2'b01, last1});
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic model_err(input bit clear_flags);
        exp_q0.push_back({2'b10, last0});
        exp_q1.push_back({2'b10, last1});
        if (clear_flags) begin
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_ext = 1'b0;
        m_brk = 1'b0;
        last0 = 10'd0;
        last1 = 10'd0;
        exp_q0.delete();
        exp_q1.delete();
    endtask

    // ------------------------------------------------------------ monitor
    initial begin : monitor
        logic [W-1:0] act;
        logic [W-1:0] e;
        logic [9:0]   prev0;
        logic [9:0]   prev1;
        prev0 = 10'd0;
        prev1 = 10'd0;
        forever begin
            @(negedge reloj);
            if (reset) begin
                prev0 = {is_break[0], is_ext[0], dato[0]};
                prev1 = {is_break[1], is_ext[1], dato[1]};
            end else begin
                act = {frame_err[0], tick[0], is_break[0], is_ext[0], dato[0]};
                compared++;
                if (tick[0] || frame_err[0]) begin
                    if (exp_q0.size() == 0) begin
                        failed++;
                        $display("FAIL mk_event: unexpected output %h, none expected (t=%0t)", act, $time);
                    end else begin
                        e = exp_q0.pop_front();
                        if (act !== e) begin
                            failed++;
                            $display("FAIL mk_event: got %h expected %h (t=%0t)", act, e, $time);
                        end
                    end
                end else if (act[9:0] !== prev0) begin
                    failed++;
                    $display("FAIL mk_hold: outputs %h changed from %h without tick (t=%0t)", act[9:0], prev0, $time);
                end
                prev0 = act[9:0];

                act = {frame_err[1], tick[1], is_break[1], is_ext[1], dato[1]};
                compared++;
                if (tick[1] || frame_err[1]) begin
                    if (exp_q1.size() == 0) begin
                        failed++;
                        $display("FAIL br_event: unexpected output %h, none expected (t=%0t)", act, $time);
                    end else begin
                        e = exp_q1.pop_front();
                        if (act !== e) begin
                            failed++;
                            $display("FAIL br_event: got %h expected %h (t=%0t)", act, e, $time);
                        end
                    end
                end else if (act[9:0] !== prev1) begin
                    failed++;
                    $display("FAIL br_hold: outputs %h changed from %h without tick (t=%0t)", act[9:0], prev1, $time);
                end
                prev1 = act[9:0];
            end
        end
    end

    // ------------------------------------------------------------ driver tasks
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge reloj);
    endtask

    task automatic send_bit(input logic v);
        ps2d = v;
        wait_cyc(HALF);
        ps2c = 1'b0;
        wait_cyc(HALF);
        ps2c = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ par_flip);
        send_bit(stop);
        ps2d = 1'b1;
        wait_cyc(2 * HALF);
    endtask

    task automatic good_frame(input logic [7:0] b);
        model_good(b);
        send_frame(b, 1'b0, 1'b1);
    endtask

    // Every expected event must have been seen by the time the line is idle.
    task automatic check_drained(input string name);
        compared++;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            failed++;
            $display("FAIL %s: %0d/%0d expected events not seen", name, exp_q0.size(), exp_q1.size());
            exp_q0.delete();
            exp_q1.delete();
        end
    endtask

    task automatic check_zero(input string name);
        for (int i = 0; i < 2; i++) begin
            compared++;
            if ({dato[i], tick[i], is_ext[i], is_break[i], frame_err[i]} !== 12'd0) begin
                failed++;
                $display("FAIL %s[%0d]: outputs %h, expected 000", name, i,
                         {dato[i], tick[i], is_ext[i], is_break[i], frame_err[i]});
            end
        end
    endtask

    // ------------------------------------------------------------ watchdog
    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed + 1);
        $fatal(1, "time limit");
    end

    // ------------------------------------------------------------ stimulus
    initial begin : stim
        logic [7:0] b;
        int         r;

        // Reset state
        wait_cyc(5);
        check_zero("reset_outputs");
        reset = 1'b0;
        wait_cyc(20);

        // Plain make code
        good_frame(8'h1C);
        check_drained("make_1c");

        // Extended prefix, then flag must not leak into the next code
        good_frame(8'hE0);
        good_frame(8'h75);
        good_frame(8'h1C);
        check_drained("ext_75");

        // Break sequence: only the REPORT_BREAK=1 receiver reports the release
        good_frame(8'h1C);
        good_frame(8'hF0);
        good_frame(8'h1C);
        check_drained("break_1c");

        // Wrong parity: error pulse, held code unchanged
        model_err(1'b0);
        send_frame(8'h1C, 1'b1, 1'b1);
        check_drained("bad_parity");

        // Frame error keeps the E0 flag; repeated E0 is harmless
        good_frame(8'hE0);
        good_frame(8'hE0);
        model_err(1'b0);
        send_frame(8'h29, 1'b0, 1'b0);
        good_frame(8'h6B);
        check_drained("err_keeps_flag");

        // Timeout after 5 data bits; it also drops a pending E0
        good_frame(8'hE0);
        model_err(1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
        ps2d = 1'b1;
        wait_cyc(TO + 200);
        check_drained("timeout");
        good_frame(8'h32);
        check_drained("after_timeout");

        // Glitches shorter than the filter length, with ps2d high, must not
        // register as a clock edge (an edge here would raise frame_err)
        ps2d = 1'b1;
        for (int g = 0; g < 6; g++) begin
            ps2c = 1'b0;
            wait_cyc(FL - 1);
            ps2c = 1'b1;
            wait_cyc(20 + $urandom_range(0, 10));
        end
        check_drained("glitch");
        good_frame(8'h4D);
        check_drained("after_glitch");

        // Randomised traffic
        for (int n = 0; n < 34; n++) begin
            r = $urandom_range(0, 15);
            b = 8'($urandom_range(0, 255));
            case (r)
                0: begin
                    model_err(1'b0);
                    send_bit(1'b1);
                    wait_cyc(2 * HALF);
                end
                1: begin
                    model_err(1'b0);
                    send_frame(b, 1'b1, 1'b1);
                end
                2: begin
                    model_err(1'b0);
                    send_frame(b, 1'b0, 1'b0);
                end
                3, 4:    good_frame(8'hE0);
                5, 6:    good_frame(8'hF0);
                default: good_frame(b);
            endcase
            check_drained("random");
        end

        // Reset in the middle of the data bits, with prefixes pending
        good_frame(8'hE0);
        good_frame(8'hF0);
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)));
        ps2d  = 1'b1;
        reset = 1'b1;
        model_reset();
        wait_cyc(3);
        check_zero("midframe_reset");
        reset = 1'b0;
        wait_cyc(20);
        good_frame(8'h1C);
        check_drained("after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
